// File: rtl/mesi_isc_cbus_agent.sv
// Per-CPU coherence-bus responder: direct-mapped MESI line table, snoop/enable handling, writeback handshake.
// Optional snoop/hit/writeback counters are enabled with `define MESI_ISC_AGENT_STATS_EN.
module mesi_isc_cbus_agent #(
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int INDEX_WIDTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
    output logic                      cbus_ack_o,
    input  logic                      cpu_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]     cpu_req_addr_i,
    output logic                      cpu_grant_o,
    output logic                      wb_req_o,
    output logic [ADDR_WIDTH-1:0]     wb_addr_o,
    input  logic                      wb_ack_i,
    input  logic [ADDR_WIDTH-1:0]     lookup_addr_i,
`ifdef MESI_ISC_AGENT_STATS_EN
    output logic [15:0]               stat_snoop_o,
    output logic [15:0]               stat_hit_o,
    output logic [15:0]               stat_wb_o,
`endif
    output logic [1:0]                lookup_state_o
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam int TAG_W   = ADDR_WIDTH - INDEX_WIDTH;

    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_NOP      = CBUS_CMD_WIDTH'(0);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;
    localparam logic [1:0] ST_M = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_ACK,
        S_WAIT_NOP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_wb_req;
    logic [ADDR_WIDTH-1:0]   r_wb_addr;
    logic                    r_wb_is_wr;
    logic                    r_grant;

    logic [ENTRIES-1:0]              w_valid_vec;
    logic [ENTRIES-1:0][TAG_W-1:0]   w_tag_vec;
    logic [ENTRIES-1:0][1:0]         w_mesi_vec;

    logic                    w_tbl_we;
    logic                    w_tbl_set_tag;
    logic [INDEX_WIDTH-1:0]  w_tbl_idx;
    logic [TAG_W-1:0]        w_tbl_tag;
    logic [1:0]              w_tbl_mesi;
    logic                    w_grant_next;
    logic                    w_wb_start;
    logic                    w_wb_done;
    logic                    w_snoop_acc;
    logic                    w_snoop_hit;

    logic [INDEX_WIDTH-1:0]  w_snp_idx;
    logic [TAG_W-1:0]        w_snp_tag;
    logic [1:0]              w_snp_mesi;
    logic [INDEX_WIDTH-1:0]  w_req_idx;
    logic [TAG_W-1:0]        w_req_tag;
    logic [INDEX_WIDTH-1:0]  w_lk_idx;
    logic [TAG_W-1:0]        w_lk_tag;
    logic [INDEX_WIDTH-1:0]  w_wb_idx;

    assign w_snp_idx = cbus_addr_i[INDEX_WIDTH-1:0];
    assign w_snp_tag = cbus_addr_i[ADDR_WIDTH-1:INDEX_WIDTH];
    assign w_req_idx = cpu_req_addr_i[INDEX_WIDTH-1:0];
    assign w_req_tag = cpu_req_addr_i[ADDR_WIDTH-1:INDEX_WIDTH];
    assign w_lk_idx  = lookup_addr_i[INDEX_WIDTH-1:0];
    assign w_lk_tag  = lookup_addr_i[ADDR_WIDTH-1:INDEX_WIDTH];
    assign w_wb_idx  = r_wb_addr[INDEX_WIDTH-1:0];

    // A tag miss reads as Invalid, so callers only need the 2-bit state.
    assign w_snp_mesi = (w_valid_vec[w_snp_idx] && (w_tag_vec[w_snp_idx] == w_snp_tag))
                        ? w_mesi_vec[w_snp_idx] : ST_I;
    assign lookup_state_o = (w_valid_vec[w_lk_idx] && (w_tag_vec[w_lk_idx] == w_lk_tag))
                            ? w_mesi_vec[w_lk_idx] : ST_I;

    // Line table: one register set per entry, all cleared by reset.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             r_valid;
            logic [TAG_W-1:0] r_tag;
            logic [1:0]       r_mesi;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid <= 1'b0;
                    r_tag   <= '0;
                    r_mesi  <= ST_I;
                end else if (w_tbl_we && (w_tbl_idx == INDEX_WIDTH'(gi))) begin
                    r_mesi <= w_tbl_mesi;
                    if (w_tbl_set_tag) begin
                        r_valid <= 1'b1;
                        r_tag   <= w_tbl_tag;
                    end
                end
            end

            assign w_valid_vec[gi] = r_valid;
            assign w_tag_vec[gi]   = r_tag;
            assign w_mesi_vec[gi]  = r_mesi;
        end
    endgenerate

    always_comb begin
        w_state_next  = r_state;
        w_tbl_we      = 1'b0;
        w_tbl_set_tag = 1'b0;
        w_tbl_idx     = '0;
        w_tbl_tag     = '0;
        w_tbl_mesi    = ST_I;
        w_grant_next  = 1'b0;
        w_wb_start    = 1'b0;
        w_wb_done     = 1'b0;
        w_snoop_acc   = 1'b0;
        w_snoop_hit   = 1'b0;

        case (r_state)
            S_IDLE: begin
                case (cbus_cmd_i)
                    CMD_WR_SNOOP: begin
                        w_snoop_acc = 1'b1;
                        w_snoop_hit = (w_snp_mesi != ST_I);
                        if (w_snp_mesi == ST_M) begin
                            w_wb_start   = 1'b1;
                            w_state_next = S_WB;
                        end else begin
                            w_tbl_we     = (w_snp_mesi != ST_I);
                            w_tbl_idx    = w_snp_idx;
                            w_tbl_mesi   = ST_I;
                            w_state_next = S_ACK;
                        end
                    end
                    CMD_RD_SNOOP: begin
                        w_snoop_acc = 1'b1;
                        w_snoop_hit = (w_snp_mesi != ST_I);
                        if (w_snp_mesi == ST_M) begin
                            w_wb_start   = 1'b1;
                            w_state_next = S_WB;
                        end else begin
                            w_tbl_we     = (w_snp_mesi == ST_E);
                            w_tbl_idx    = w_snp_idx;
                            w_tbl_mesi   = ST_S;
                            w_state_next = S_ACK;
                        end
                    end
                    CMD_EN_WR, CMD_EN_RD: begin
                        // Without a pending request the enable is acked but otherwise dropped.
                        w_tbl_we      = cpu_req_valid_i;
                        w_tbl_set_tag = 1'b1;
                        w_tbl_idx     = w_req_idx;
                        w_tbl_tag     = w_req_tag;
                        w_tbl_mesi    = (cbus_cmd_i == CMD_EN_WR) ? ST_M : ST_S;
                        w_grant_next  = cpu_req_valid_i;
                        w_state_next  = S_ACK;
                    end
                    default: w_state_next = S_IDLE;
                endcase
            end
            S_WB: begin
                if (wb_ack_i) begin
                    w_wb_done    = 1'b1;
                    w_tbl_we     = 1'b1;
                    w_tbl_idx    = w_wb_idx;
                    w_tbl_mesi   = r_wb_is_wr ? ST_I : ST_S;
                    w_state_next = S_ACK;
                end
            end
            S_ACK: w_state_next = S_WAIT_NOP;
            S_WAIT_NOP: begin
                // The controller holds its command until it sees the ack; wait for it to let go.
                if (cbus_cmd_i == CMD_NOP) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wb_req   <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_is_wr <= 1'b0;
            r_grant    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            if (w_wb_start) begin
                r_wb_req   <= 1'b1;
                r_wb_addr  <= cbus_addr_i;
                r_wb_is_wr <= (cbus_cmd_i == CMD_WR_SNOOP);
            end else if (w_wb_done) begin
                r_wb_req <= 1'b0;
            end
        end
    end

    assign cbus_ack_o  = (r_state == S_ACK);
    assign cpu_grant_o = r_grant;
    assign wb_req_o    = r_wb_req;
    assign wb_addr_o   = r_wb_addr;

`ifdef MESI_ISC_AGENT_STATS_EN
    logic [15:0] r_stat_snoop;
    logic [15:0] r_stat_hit;
    logic [15:0] r_stat_wb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_snoop <= '0;
            r_stat_hit   <= '0;
            r_stat_wb    <= '0;
        end else begin
            if (w_snoop_acc && (r_stat_snoop != 16'hFFFF)) begin
                r_stat_snoop <= r_stat_snoop + 16'd1;
            end
            if (w_snoop_hit && (r_stat_hit != 16'hFFFF)) begin
                r_stat_hit <= r_stat_hit + 16'd1;
            end
            if (w_wb_done && (r_stat_wb != 16'hFFFF)) begin
                r_stat_wb <= r_stat_wb + 16'd1;
            end
        end
    end

    assign stat_snoop_o = r_stat_snoop;
    assign stat_hit_o   = r_stat_hit;
    assign stat_wb_o    = r_stat_wb;
`else
    logic w_stats_unused;
    assign w_stats_unused = w_snoop_acc | w_snoop_hit;
`endif

endmodule

// File: tb/tb_mesi_isc_cbus_agent.sv
// Randomized bench for mesi_isc_cbus_agent: acts as the broadcast controller and checks against a line-table model.
module tb_mesi_isc_cbus_agent;

    localparam int AW = 32;
    localparam int IW = 2;
    localparam int NE = 4;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_WRS = 3'd1;
    localparam logic [2:0] C_RDS = 3'd2;
    localparam logic [2:0] C_ENW = 3'd3;
    localparam logic [2:0] C_ENR = 3'd4;

    logic          clk;
    logic          rst;
    logic [2:0]    cbus_cmd_i;
    logic [AW-1:0] cbus_addr_i;
    logic          cbus_ack_o;
    logic          cpu_req_valid_i;
    logic [AW-1:0] cpu_req_addr_i;
    logic          cpu_grant_o;
    logic          wb_req_o;
    logic [AW-1:0] wb_addr_o;
    logic          wb_ack_i;
    logic [AW-1:0] lookup_addr_i;
    logic [1:0]    lookup_state_o;
`ifdef MESI_ISC_AGENT_STATS_EN
    logic [15:0]   stat_snoop_o;
    logic [15:0]   stat_hit_o;
    logic [15:0]   stat_wb_o;
`endif

    mesi_isc_cbus_agent #(
        .CBUS_CMD_WIDTH(3),
        .ADDR_WIDTH    (AW),
        .INDEX_WIDTH   (IW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cbus_cmd_i     (cbus_cmd_i),
        .cbus_addr_i    (cbus_addr_i),
        .cbus_ack_o     (cbus_ack_o),
        .cpu_req_valid_i(cpu_req_valid_i),
        .cpu_req_addr_i (cpu_req_addr_i),
        .cpu_grant_o    (cpu_grant_o),
        .wb_req_o       (wb_req_o),
        .wb_addr_o      (wb_addr_o),
        .wb_ack_i       (wb_ack_i),
        .lookup_addr_i  (lookup_addr_i),
`ifdef MESI_ISC_AGENT_STATS_EN
        .stat_snoop_o   (stat_snoop_o),
        .stat_hit_o     (stat_hit_o),
        .stat_wb_o      (stat_wb_o),
`endif
        .lookup_state_o (lookup_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_txn = 0;

    // Reference: resident line per index (address-level view), MESI state as 0..3.
    bit            mdl_valid [NE];
    logic [AW-1:0] mdl_line  [NE];
    int            mdl_st    [NE];
    int            mdl_snoop, mdl_hit, mdl_wb;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mdl_lookup(input logic [AW-1:0] a);
        int idx;
        idx = int'(a % NE);
        if (mdl_valid[idx] && (mdl_line[idx] / NE == a / NE)) return mdl_st[idx];
        return 0;
    endfunction

    function automatic void mdl_reset();
        for (int i = 0; i < NE; i++) begin
            mdl_valid[i] = 1'b0;
            mdl_line[i]  = '0;
            mdl_st[i]    = 0;
        end
        mdl_snoop = 0;
        mdl_hit   = 0;
        mdl_wb    = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_table(input string tag);
        for (int a = 0; a < 16; a++) begin
            lookup_addr_i = AW'(a);
            #1;
            chk_val(tag, 32'(lookup_state_o), 32'(mdl_lookup(AW'(a))));
        end
    endtask

    // One controller transaction: drive cmd, service writeback, check ack/grant/state, then return to NOP.
    task automatic do_txn(input logic [2:0] cmd, input logic [AW-1:0] addr, input bit req_v,
                          input logic [AW-1:0] req_addr, input int wb_wait, input int hold);
        bit            is_snp, is_en, exp_wb, exp_grant, got_ack, stray_grant;
        int            pre, exp_st, cyc, wbc, idx;
        logic [AW-1:0] chk_addr;

        is_snp    = (cmd == C_WRS) || (cmd == C_RDS);
        is_en     = (cmd == C_ENW) || (cmd == C_ENR);
        pre       = mdl_lookup(addr);
        exp_wb    = is_snp && (pre == 3);
        exp_grant = is_en && req_v;
        chk_addr  = is_en ? req_addr : addr;

        if (is_snp) begin
            mdl_snoop++;
            if (pre != 0) mdl_hit++;
            if (exp_wb) mdl_wb++;
            idx = int'(addr % NE);
            if (cmd == C_WRS && pre != 0) mdl_st[idx] = 0;
            if (cmd == C_RDS && (pre == 2 || pre == 3)) mdl_st[idx] = 1;
        end
        if (exp_grant) begin
            idx = int'(req_addr % NE);
            mdl_valid[idx] = 1'b1;
            mdl_line[idx]  = req_addr;
            mdl_st[idx]    = (cmd == C_ENW) ? 3 : 1;
        end
        exp_st = mdl_lookup(chk_addr);

        cbus_cmd_i      = cmd;
        cbus_addr_i     = addr;
        cpu_req_valid_i = req_v;
        cpu_req_addr_i  = req_addr;
        lookup_addr_i   = chk_addr;
        cyc = 0; wbc = 0; got_ack = 0; stray_grant = 0;
        while (!got_ack && cyc < 40) begin
            tick();
            cyc++;
            wb_ack_i = 1'b0;
            if (wb_req_o) begin
                wbc++;
                if (wbc == 1) chk_val("wb_addr", wb_addr_o, addr);
                if (wbc == wb_wait) wb_ack_i = 1'b1;
            end
            if (cbus_ack_o) begin
                got_ack = 1;
                chk_val("grant", 32'(cpu_grant_o), 32'(exp_grant));
                chk_val("state", 32'(lookup_state_o), 32'(exp_st));
                chk_val("wb_drop", 32'(wb_req_o), 32'd0);
            end else if (cpu_grant_o) begin
                stray_grant = 1;
            end
        end
        wb_ack_i = 1'b0;
        chk_val("ack_seen", 32'(got_ack), 32'd1);
        chk_val("latency", 32'(cyc), exp_wb ? 32'(1 + wb_wait) : 32'd1);
        chk_val("wb_cycles", 32'(wbc), exp_wb ? 32'(wb_wait) : 32'd0);
        chk_val("stray_grant", 32'(stray_grant), 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk_val("dup_ack", 32'(cbus_ack_o), 32'd0);
        end
        cbus_cmd_i      = C_NOP;
        cpu_req_valid_i = 1'b0;
        for (int h = 0; h < 2; h++) begin
            tick();
            chk_val("nop_ack", 32'(cbus_ack_o | cpu_grant_o), 32'd0);
        end
        n_txn++;
        $display("txn %0d cmd=%0d addr=%08h req_v=%0d ack_cyc=%0d wb_cyc=%0d state=%0d",
                 n_txn, cmd, addr, req_v, cyc, wbc, lookup_state_o);
    endtask

    initial begin
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        bit            rv;
        int            r;

        mdl_reset();
        rst             = 1'b0;
        cbus_cmd_i      = C_NOP;
        cbus_addr_i     = '0;
        cpu_req_valid_i = 1'b0;
        cpu_req_addr_i  = '0;
        wb_ack_i        = 1'b0;
        lookup_addr_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_outs", {29'd0, cbus_ack_o, cpu_grant_o, wb_req_o}, 32'd0);
        chk_val("rst_wbaddr", wb_addr_o, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk_val("idle_outs", {29'd0, cbus_ack_o, cpu_grant_o, wb_req_o}, 32'd0);
        end
        chk_table("init_table");

        do_txn(C_ENR, 32'h10, 1'b1, 32'h10, 1, 0);
        do_txn(C_WRS, 32'h10, 1'b0, 32'h0, 1, 3);
        do_txn(C_ENW, 32'h23, 1'b1, 32'h23, 1, 0);
        do_txn(C_RDS, 32'h23, 1'b0, 32'h0, 4, 0);
        do_txn(C_ENW, 32'h23, 1'b1, 32'h23, 1, 1);
        do_txn(C_WRS, 32'h27, 1'b0, 32'h0, 1, 0);
        lookup_addr_i = 32'h23;
        #1;
        chk_val("resident_m", 32'(lookup_state_o), 32'd3);
        do_txn(C_WRS, 32'h23, 1'b0, 32'h0, 2, 0);
        do_txn(C_ENR, 32'h5, 1'b0, 32'h5, 1, 0);
        chk_table("after_directed");

        // Reset while a writeback is in flight.
        do_txn(C_ENW, 32'h31, 1'b1, 32'h31, 1, 0);
        cbus_cmd_i  = C_RDS;
        cbus_addr_i = 32'h31;
        tick();
        chk_val("wb_started", 32'(wb_req_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_val("async_rst", {29'd0, cbus_ack_o, cpu_grant_o, wb_req_o}, 32'd0);
        chk_val("async_wbaddr", wb_addr_o, 32'd0);
        mdl_reset();
        cbus_cmd_i = C_NOP;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_val("post_rst", {30'd0, cbus_ack_o, wb_req_o}, 32'd0);
        end
        chk_table("post_rst_table");

        for (int t = 0; t < 300; t++) begin
            r    = $urandom_range(0, 9);
            addr = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) addr = AW'($urandom);
            rv   = 1'b1;
            if (r <= 2)      cmd = C_RDS;
            else if (r <= 5) cmd = C_WRS;
            else if (r <= 7) cmd = C_ENW;
            else if (r == 8) cmd = C_ENR;
            else begin
                cmd = ($urandom_range(0, 1) == 1) ? C_ENW : C_ENR;
                rv  = 1'b0;
            end
            do_txn(cmd, addr, rv, addr, int'($urandom_range(1, 5)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin
                cbus_cmd_i = 3'(5 + $urandom_range(0, 2));
                wb_ack_i   = 1'b1;
                tick();
                cbus_cmd_i = C_NOP;
                wb_ack_i   = 1'b0;
                chk_val("undef_cmd", {30'd0, cbus_ack_o, wb_req_o}, 32'd0);
            end
        end
        chk_table("final_table");

`ifdef MESI_ISC_AGENT_STATS_EN
        chk_val("stat_snoop", 32'(stat_snoop_o), 32'((mdl_snoop > 65535) ? 65535 : mdl_snoop));
        chk_val("stat_hit", 32'(stat_hit_o), 32'((mdl_hit > 65535) ? 65535 : mdl_hit));
        chk_val("stat_wb", 32'(stat_wb_o), 32'((mdl_wb > 65535) ? 65535 : mdl_wb));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
